// File: rtl/vga_sync.sv
// VGA sync generator: pixel-rate enable at clk/2, horizontal/vertical counters,
// registered active-low syncs aligned with the counters, visible-area and frame-end flags.
module vga_sync #(
    parameter int HD = 640,
    parameter int HF = 16,
    parameter int HR = 96,
    parameter int HB = 48,
    parameter int VD = 480,
    parameter int VF = 10,
    parameter int VR = 2,
    parameter int VB = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic       frame_tick,
    output logic [9:0] hcount,
    output logic [9:0] vcount
);

    localparam int HT = HD + HF + HR + HB;
    localparam int VT = VD + VF + VR + VB;

    localparam logic [9:0] H_MAX       = 10'(HT - 1);
    localparam logic [9:0] V_MAX       = 10'(VT - 1);
    localparam logic [9:0] H_DISP      = 10'(HD);
    localparam logic [9:0] V_DISP      = 10'(VD);
    localparam logic [9:0] HSYNC_FIRST = 10'(HD + HF);
    localparam logic [9:0] HSYNC_LAST  = 10'(HD + HF + HR - 1);
    localparam logic [9:0] VSYNC_FIRST = 10'(VD + VF);
    localparam logic [9:0] VSYNC_LAST  = 10'(VD + VF + VR - 1);

    logic       r_div;
    logic [9:0] r_hcount;
    logic [9:0] r_vcount;
    logic       r_hsync;
    logic       r_vsync;

    logic [9:0] w_hcount_next;
    logic [9:0] w_vcount_next;
    logic       w_h_end;
    logic       w_v_end;
    logic       w_hsync_next;
    logic       w_vsync_next;

    assign w_h_end = (r_hcount == H_MAX);
    assign w_v_end = (r_vcount == V_MAX);

    // Counters move only on pixel-enable cycles; vcount steps as hcount wraps.
    always_comb begin
        w_hcount_next = r_hcount;
        w_vcount_next = r_vcount;
        if (r_div) begin
            if (w_h_end) begin
                w_hcount_next = 10'd0;
                if (w_v_end) begin
                    w_vcount_next = 10'd0;
                end else begin
                    w_vcount_next = r_vcount + 10'd1;
                end
            end else begin
                w_hcount_next = r_hcount + 10'd1;
            end
        end
    end

    // Syncs decode the next-state counters so the registered pulse lines up with the counters.
    assign w_hsync_next = !((w_hcount_next >= HSYNC_FIRST) && (w_hcount_next <= HSYNC_LAST));
    assign w_vsync_next = !((w_vcount_next >= VSYNC_FIRST) && (w_vcount_next <= VSYNC_LAST));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div    <= 1'b0;
            r_hcount <= 10'd0;
            r_vcount <= 10'd0;
            r_hsync  <= 1'b1;
            r_vsync  <= 1'b1;
        end else begin
            r_div    <= ~r_div;
            r_hcount <= w_hcount_next;
            r_vcount <= w_vcount_next;
            r_hsync  <= w_hsync_next;
            r_vsync  <= w_vsync_next;
        end
    end

    assign p_tick     = r_div;
    assign hcount     = r_hcount;
    assign vcount     = r_vcount;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign video_on   = (r_hcount < H_DISP) && (r_vcount < V_DISP);
    assign frame_tick = r_div && w_h_end && w_v_end;

endmodule

// File: doc/vga_sync.md
VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 The block SHALL have a single clock, clk, and a synchronous active-high reset, reset; all state SHALL update only on the rising edge of clk.
REQ-002 Parameter HD, default 640, SHALL set the horizontal display width in pixels.
REQ-003 Parameter HF, default 16, SHALL set the horizontal front porch in pixels.
REQ-004 Parameter HR, default 96, SHALL set the horizontal sync width in pixels.
REQ-005 Parameter HB, default 48, SHALL set the horizontal back porch in pixels.
REQ-006 Parameter VD, default 480, SHALL set the vertical display height in lines.
REQ-007 Parameter VF, default 10, SHALL set the vertical front porch in lines.
REQ-008 Parameter VR, default 2, SHALL set the vertical sync width in lines.
REQ-009 Parameter VB, default 33, SHALL set the vertical back porch in lines.
REQ-010 Port clk, input, 1 bit, SHALL be the 50 MHz system clock.
REQ-011 Port reset, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-012 Port hsync, output, 1 bit, SHALL be the horizontal sync, active low.
REQ-013 Port vsync, output, 1 bit, SHALL be the vertical sync, active low.
REQ-014 Port video_on, output, 1 bit, SHALL be high only while the current pixel lies in the visible area.
REQ-015 Port p_tick, output, 1 bit, SHALL be the pixel-rate enable at clk/2 (25 MHz).
REQ-016 Port frame_tick, output, 1 bit, SHALL be a one-clk pulse marking the last pixel of a frame.
REQ-017 Port hcount, output, 10 bits, SHALL be the current pixel column (0..HT-1).
REQ-018 Port vcount, output, 10 bits, SHALL be the current line (0..VT-1).

Function
REQ-019 The block SHALL define HT = HD+HF+HR+HB (800) and VT = VD+VF+VR+VB (525).
REQ-020 A 1-bit divider register SHALL toggle every clk, and p_tick SHALL equal the divider value, so p_tick is high on exactly every second clk.
REQ-021 hcount SHALL advance only on clk edges where p_tick=1, and SHALL wrap from HT-1 (799) to 0.
REQ-022 vcount SHALL advance only on clk edges where p_tick=1 and hcount=HT-1, and SHALL wrap from VT-1 (524) to 0 in the same edge that hcount wraps.
REQ-023 On all other clk edges, hcount and vcount SHALL hold their values.
REQ-024 hsync SHALL be a register loaded from the next-state hcount, and SHALL be 0 exactly while hcount is in [HD+HF, HD+HF+HR-1] ([656,751]), with zero cycles of skew relative to hcount.
REQ-025 vsync SHALL be a register loaded from the next-state vcount, and SHALL be 0 exactly while vcount is in [VD+VF, VD+VF+VR-1] ([490,491]), with zero cycles of skew relative to vcount.
REQ-026 video_on SHALL be 1 exactly when hcount<HD and vcount<VD, derived combinationally from the registered counters.
REQ-027 frame_tick SHALL be 1 exactly when p_tick=1, hcount=HT-1 and vcount=VT-1.
REQ-028 hcount and vcount SHALL drive downstream pixel logic directly; the pixel logic SHALL see a given (hcount,vcount) pair for exactly 2 clk.
REQ-029 Counter arithmetic SHALL be unsigned 10-bit; the values HT-1 and VT-1 SHALL never be exceeded.

Reset
REQ-030 While reset=1, the divider, hcount and vcount SHALL be 0, and hsync and vsync SHALL be 1.
REQ-031 While reset=1, p_tick and frame_tick SHALL be 0, and video_on SHALL be 1, consistent with counters at (0,0).
REQ-032 When reset is asserted mid-frame, the block SHALL restart from (0,0) on the next clk edge, with no partial sync pulse carried over.
REQ-033 After reset deasserts, p_tick SHALL first be 1 on the first clk following release, and hcount SHALL become 1 on the edge that follows.

Verification
REQ-034 The bench SHALL check reset: hold reset 3 clk -> hcount=0, vcount=0, hsync=1, vsync=1, p_tick=0, video_on=1.
REQ-035 The bench SHALL check p_tick: 20 clk after reset -> p_tick alternates 0/1, and hcount increments once per 2 clk.
REQ-036 The bench SHALL check the line wrap: run to hcount=799, vcount=0 -> the next p_tick edge gives hcount=0, vcount=1, and video_on was 0 for hcount 640..799.
REQ-037 The bench SHALL check hsync and vsync: hsync low for exactly 96 pixels (192 clk) starting at hcount=656, and vsync low only for vcount 490..491 (1600 pixels).
REQ-038 The bench SHALL check frame timing: frame_tick pulses exactly once per 840000 clk, coincident with (799,524), and the counters read (0,0) on the next p_tick edge.
REQ-039 The bench SHALL check mid-frame reset: assert reset for 1 clk at (700,491) with vsync low -> the next state is (0,0), vsync=1, hsync=1, and normal counting resumes.
